// File: rtl/apb_req_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface  : apb_req_arbiter_if                                            |
// | Purpose    : Bundles the two requester ports and the downstream APB-master |
// |              trigger port of apb_req_arbiter.                              |
// | Signals    : rN_req/rN_addr/rN_wdata/rN_write  requester N request         |
// |              rN_ready/rN_rdata                 requester N completion      |
// |              transfer/addr/wdata/write         trigger to the APB master   |
// |              ready/rdata                       APB master completion       |
// |              err                               timeout flag                |
// | Modports   : master - the arbiter itself                                   |
// |              slave  - the surrounding requesters and APB master            |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
interface apb_req_arbiter_if;
  logic        r0_req;
  logic [31:0] r0_addr;
  logic [31:0] r0_wdata;
  logic        r0_write;
  logic        r0_ready;
  logic [31:0] r0_rdata;

  logic        r1_req;
  logic [31:0] r1_addr;
  logic [31:0] r1_wdata;
  logic        r1_write;
  logic        r1_ready;
  logic [31:0] r1_rdata;

  logic        transfer;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        write;
  logic        ready;
  logic [31:0] rdata;
  logic        err;

  modport master (
    input  r0_req, r0_addr, r0_wdata, r0_write,
    input  r1_req, r1_addr, r1_wdata, r1_write,
    input  ready, rdata,
    output r0_ready, r0_rdata, r1_ready, r1_rdata,
    output transfer, addr, wdata, write, err
  );

  modport slave (
    output r0_req, r0_addr, r0_wdata, r0_write,
    output r1_req, r1_addr, r1_wdata, r1_write,
    output ready, rdata,
    input  r0_ready, r0_rdata, r1_ready, r1_rdata,
    input  transfer, addr, wdata, write, err
  );
endinterface
`default_nettype wire

// File: rtl/apb_req_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : apb_req_arbiter                                               |
// | Purpose    : Round-robin arbiter sharing the APB master trigger interface  |
// |              between requester 0 (core data port) and requester 1         |
// |              (secondary bus master). One transaction in flight at a time. |
// | Ports      : PCLK    system clock                                          |
// |              PRESET  asynchronous active-high reset                        |
// |              bus     apb_req_arbiter_if.master (requesters + APB trigger)  |
// | Parameters : TIMEOUT_CYCLES  ready watchdog limit (timeout build only)     |
// |              ERR_DATA        read data returned on a timed-out access      |
// | Options    : APB_ARB_TIMEOUT_EN  enables the downstream ready watchdog;    |
// |              when undefined WAIT lasts until ready and err is tied 0.      |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module apb_req_arbiter #(
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input wire                PCLK,
  input wire                PRESET,
  apb_req_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_last_grant;
  logic        r_gnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_write;
  logic [31:0] r_rdata0;
  logic [31:0] r_rdata1;

  logic        w_any_req;
  logic        w_grant;
  logic        w_complete;
  logic        w_timeout;
  logic [31:0] w_cpl_data;
  logic        w_transfer;
  logic        w_r0_ready;
  logic        w_r1_ready;
  logic        w_err;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int                 c_cnt_w    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_tmo_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

  logic [c_cnt_w-1:0] r_tmo_cnt;
  logic               r_err;
`else
  // Configuration values only matter to the watchdog build.
  logic [63:0] w_unused_cfg;
  assign w_unused_cfg = {ERR_DATA, 32'(TIMEOUT_CYCLES)};
`endif

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and decoded outputs. Outputs depend only on registered state,
  // so there is no combinational path from rN_req to transfer.
  always_comb begin
    w_state_nxt = r_state;
    w_complete  = 1'b0;
    w_transfer  = 1'b0;
    w_r0_ready  = 1'b0;
    w_r1_ready  = 1'b0;
    w_err       = 1'b0;
    w_any_req   = bus.r0_req | bus.r1_req;
    // Tie goes to whoever was not served last; otherwise the lone requester.
    w_grant     = (bus.r0_req & bus.r1_req) ? ~r_last_grant : bus.r1_req;
`ifdef APB_ARB_TIMEOUT_EN
    // A ready arriving on the final count still wins over the timeout.
    w_timeout   = (r_state == S_WAIT) && !bus.ready && (r_tmo_cnt == c_tmo_last);
    w_cpl_data  = w_timeout ? ERR_DATA : bus.rdata;
`else
    w_timeout   = 1'b0;
    w_cpl_data  = bus.rdata;
`endif

    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_transfer  = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bus.ready || w_timeout) begin
          w_complete  = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_r0_ready  = ~r_gnt;
        w_r1_ready  = r_gnt;
`ifdef APB_ARB_TIMEOUT_EN
        w_err       = r_err;
`endif
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_last_grant <= 1'b1;
      r_gnt        <= 1'b0;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_write      <= 1'b0;
      r_rdata0     <= 32'd0;
      r_rdata1     <= 32'd0;
    end else begin
      if ((r_state == S_IDLE) && w_any_req) begin
        r_gnt   <= w_grant;
        r_addr  <= w_grant ? bus.r1_addr  : bus.r0_addr;
        r_wdata <= w_grant ? bus.r1_wdata : bus.r0_wdata;
        r_write <= w_grant ? bus.r1_write : bus.r0_write;
      end
      if (w_complete) begin
        r_last_grant <= r_gnt;
        if (r_gnt) begin
          r_rdata1 <= w_cpl_data;
        end else begin
          r_rdata0 <= w_cpl_data;
        end
      end
    end
  end

`ifdef APB_ARB_TIMEOUT_EN
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_tmo_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      // Cleared while issuing, so the first WAIT cycle sees zero.
      if (r_state == S_ISSUE) begin
        r_tmo_cnt <= '0;
      end else if (r_state == S_WAIT) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
      if (w_complete) begin
        r_err <= w_timeout;
      end
    end
  end
`endif

  assign bus.transfer = w_transfer;
  assign bus.addr     = r_addr;
  assign bus.wdata    = r_wdata;
  assign bus.write    = r_write;
  assign bus.r0_ready = w_r0_ready;
  assign bus.r1_ready = w_r1_ready;
  assign bus.r0_rdata = r_rdata0;
  assign bus.r1_rdata = r_rdata1;
  assign bus.err      = w_err;

endmodule
`default_nettype wire

// File: tb/tb_apb_req_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_apb_req_arbiter                                            |
// | Purpose    : Self-checking bench for apb_req_arbiter. Requesters are fed   |
// |              from transaction queues, a small APB slave model answers     |
// |              three cycles after each transfer, and expected read data is  |
// |              queued when each request is issued.                          |
// | Options    : APB_ARB_TIMEOUT_EN adds the watchdog scenario.               |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module tb_apb_req_arbiter;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
  } txn_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
    int          cyc;
  } xfer_t;

  typedef struct {
    int          who;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } done_t;

  logic PCLK = 1'b0;
  logic PRESET;
  logic slave_hang;
  logic inject_ready;
  logic done_flag0;
  logic done_flag1;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int tx_rd0, tx_rd1;
  int e0, e1;

  txn_t        txq0[$];
  txn_t        txq1[$];
  logic [31:0] expq0[$];
  logic [31:0] expq1[$];
  xfer_t       xfer_log[$];
  done_t       done_log[$];
  xfer_t       xe;
  done_t       de;

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  apb_req_arbiter_if bus ();

  apb_req_arbiter #(
    .TIMEOUT_CYCLES(16),
    .ERR_DATA      (32'hDEAD_BEEF)
  ) dut (
    .PCLK  (PCLK),
    .PRESET(PRESET),
    .bus   (bus)
  );

  function automatic logic [31:0] slave_fn(input logic [31:0] a);
    if (a == 32'h1000_0000) return 32'h0000_00A5;
    return (a ^ 32'h5A5A_0000) + 32'h11;
  endfunction

  // Monitor: logs transfers and completions.
  always @(negedge PCLK) begin
    done_flag0 = bus.r0_ready;
    done_flag1 = bus.r1_ready;
    if (bus.transfer) begin
      xe.addr = bus.addr; xe.wdata = bus.wdata; xe.write = bus.write; xe.cyc = cyc;
      xfer_log.push_back(xe);
    end
    if (bus.r0_ready) begin
      de.who = 0; de.rdata = bus.r0_rdata; de.err = bus.err; de.cyc = cyc;
      done_log.push_back(de);
    end
    if (bus.r1_ready) begin
      de.who = 1; de.rdata = bus.r1_rdata; de.err = bus.err; de.cyc = cyc;
      done_log.push_back(de);
    end
  end

  // APB slave model: ready three cycles after transfer.
  initial begin : slv
    int          cnt;
    logic [31:0] a;
    cnt = 0; a = 32'd0;
    bus.ready = 1'b0; bus.rdata = 32'd0;
    forever begin
      @(negedge PCLK);
      if (PRESET) cnt = 0;
      else if (bus.transfer) begin cnt = 3; a = bus.addr; end
      @(posedge PCLK); #1;
      bus.ready = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0 && !slave_hang) begin bus.ready = 1'b1; bus.rdata = slave_fn(a); end
      end else if (inject_ready) begin
        bus.ready = 1'b1; bus.rdata = 32'h1234_5678;
      end
    end
  end

  // Requester drivers: hold each request until its ready, then reissue or drop.
  initial begin : drv
    bit   busy0, busy1;
    txn_t t;
    busy0 = 0; busy1 = 0; tx_rd0 = 0; tx_rd1 = 0;
    bus.r0_req = 0; bus.r0_addr = 0; bus.r0_wdata = 0; bus.r0_write = 0;
    bus.r1_req = 0; bus.r1_addr = 0; bus.r1_wdata = 0; bus.r1_write = 0;
    forever begin
      @(posedge PCLK); #1;
      if (PRESET) begin
        busy0 = 0; busy1 = 0; bus.r0_req = 0; bus.r1_req = 0;
        tx_rd0 = txq0.size(); tx_rd1 = txq1.size();
      end else begin
        if (busy0 && done_flag0) busy0 = 0;
        if (!busy0) begin
          if (tx_rd0 < txq0.size()) begin
            t = txq0[tx_rd0]; tx_rd0++; busy0 = 1;
            bus.r0_addr = t.addr; bus.r0_wdata = t.wdata; bus.r0_write = t.write; bus.r0_req = 1;
            expq0.push_back(slave_hang ? 32'hDEAD_BEEF : slave_fn(t.addr));
          end else bus.r0_req = 0;
        end
        if (busy1 && done_flag1) busy1 = 0;
        if (!busy1) begin
          if (tx_rd1 < txq1.size()) begin
            t = txq1[tx_rd1]; tx_rd1++; busy1 = 1;
            bus.r1_addr = t.addr; bus.r1_wdata = t.wdata; bus.r1_write = t.write; bus.r1_req = 1;
            expq1.push_back(slave_hang ? 32'hDEAD_BEEF : slave_fn(t.addr));
          end else bus.r1_req = 0;
        end
      end
    end
  end

  task automatic push_txn(input int n, input logic [31:0] a, input logic [31:0] w, input logic wr);
    txn_t t;
    t.addr = a; t.wdata = w; t.write = wr;
    if (n == 0) txq0.push_back(t); else txq1.push_back(t);
  endtask

  task automatic wait_done(input int target, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge PCLK);
      if (done_log.size() >= target) begin ok = 1; break; end
    end
  endtask

  task automatic do_reset();
    @(negedge PCLK); PRESET = 1'b1;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK); PRESET = 1'b0;
    e0 = expq0.size(); e1 = expq1.size();
  endtask

  task automatic test_reset();
    int bd, bx;
    logic [132:0] v;
    repeat (3) @(posedge PCLK); #1;
    v = {bus.transfer, bus.r0_ready, bus.r1_ready, bus.err, bus.write,
         bus.addr, bus.wdata, bus.r0_rdata, bus.r1_rdata};
    n_checks++;
    if (v !== '0) $display("FAIL reset_outputs: got %h expected 0", v); else n_pass++;
    @(negedge PCLK); PRESET = 1'b0;
    bd = done_log.size(); bx = xfer_log.size();
    @(negedge PCLK); inject_ready = 1'b1;
    @(negedge PCLK); inject_ready = 1'b0;
    repeat (5) @(posedge PCLK);
    n_checks++;
    if (done_log.size() - bd !== 0) $display("FAIL idle_ready_done: got %0d completions expected 0", done_log.size() - bd);
    else n_pass++;
    n_checks++;
    if (xfer_log.size() - bx !== 0) $display("FAIL idle_ready_xfer: got %0d transfers expected 0", xfer_log.size() - bx);
    else n_pass++;
  endtask

  task automatic test_single_read();
    int bd, bx; bit ok;
    bd = done_log.size(); bx = xfer_log.size();
    @(negedge PCLK); push_txn(0, 32'h1000_0000, 32'd0, 1'b0);
    wait_done(bd + 1, 40, ok);
    repeat (4) @(posedge PCLK); #1;
    n_checks++;
    if (!ok) $display("FAIL single_done: got no r0_ready expected one"); else n_pass++;
    n_checks++;
    if (xfer_log.size() - bx !== 1) $display("FAIL single_xfer_count: got %0d expected 1", xfer_log.size() - bx);
    else n_pass++;
    n_checks++;
    if (done_log.size() - bd !== 1) $display("FAIL single_done_count: got %0d expected 1", done_log.size() - bd);
    else n_pass++;
    if (ok && xfer_log.size() > bx) begin
      n_checks++;
      if ({xfer_log[bx].addr, xfer_log[bx].write} !== {32'h1000_0000, 1'b0})
        $display("FAIL single_xfer: got addr %h write %b expected 10000000/0", xfer_log[bx].addr, xfer_log[bx].write);
      else n_pass++;
      n_checks++;
      if (done_log[bd].who !== 0 || done_log[bd].rdata !== expq0[e0] || done_log[bd].err !== 1'b0)
        $display("FAIL single_rdata: got r%0d %h err %b expected r0 %h err 0",
                 done_log[bd].who, done_log[bd].rdata, done_log[bd].err, expq0[e0]);
      else n_pass++;
      n_checks++;
      if (done_log[bd].cyc - xfer_log[bx].cyc !== 4)
        $display("FAIL single_latency: got %0d expected 4", done_log[bd].cyc - xfer_log[bx].cyc);
      else n_pass++;
    end
    n_checks++;
    if (bus.r0_rdata !== 32'h0000_00A5) $display("FAIL single_hold: got %h expected 000000a5", bus.r0_rdata);
    else n_pass++;
    e0++;
  endtask

  task automatic test_simultaneous();
    int bd, bx; bit ok;
    do_reset();
    bd = done_log.size(); bx = xfer_log.size();
    @(negedge PCLK);
    push_txn(0, 32'h1000_2000, 32'h0000_0055, 1'b1);
    push_txn(1, 32'h1000_3000, 32'd0, 1'b0);
    wait_done(bd + 2, 60, ok);
    repeat (4) @(posedge PCLK);
    n_checks++;
    if (!ok || xfer_log.size() - bx !== 2)
      $display("FAIL simul_count: got %0d transfers expected 2", xfer_log.size() - bx);
    else n_pass++;
    if (ok && xfer_log.size() - bx == 2) begin
      n_checks++;
      if (done_log[bd].who !== 0 || done_log[bd + 1].who !== 1)
        $display("FAIL simul_order: got r%0d,r%0d expected r0,r1", done_log[bd].who, done_log[bd + 1].who);
      else n_pass++;
      n_checks++;
      if ({xfer_log[bx].addr, xfer_log[bx].write, xfer_log[bx].wdata} !== {32'h1000_2000, 1'b1, 32'h55})
        $display("FAIL simul_xfer0: got %h/%b/%h expected 10002000/1/00000055",
                 xfer_log[bx].addr, xfer_log[bx].write, xfer_log[bx].wdata);
      else n_pass++;
      n_checks++;
      if ({xfer_log[bx + 1].addr, xfer_log[bx + 1].write} !== {32'h1000_3000, 1'b0})
        $display("FAIL simul_xfer1: got %h/%b expected 10003000/0", xfer_log[bx + 1].addr, xfer_log[bx + 1].write);
      else n_pass++;
      n_checks++;
      if (xfer_log[bx + 1].cyc <= done_log[bd].cyc)
        $display("FAIL simul_serial: got r1 transfer cycle %0d expected after %0d", xfer_log[bx + 1].cyc, done_log[bd].cyc);
      else n_pass++;
      n_checks++;
      if (done_log[bd + 1].rdata !== expq1[e1])
        $display("FAIL simul_rdata1: got %h expected %h", done_log[bd + 1].rdata, expq1[e1]);
      else n_pass++;
    end
    e0 = expq0.size(); e1 = expq1.size();
  endtask

  task automatic test_back_to_back();
    int bd, bx; bit ok;
    bd = done_log.size(); bx = xfer_log.size();
    @(negedge PCLK);
    for (int i = 0; i < 4; i++) push_txn(1, 32'h1000_4000 + 32'(4 * i), 32'd0, 1'b0);
    wait_done(bd + 4, 100, ok);
    repeat (4) @(posedge PCLK);
    n_checks++;
    if (!ok || xfer_log.size() - bx !== 4)
      $display("FAIL b2b_count: got %0d transfers expected 4", xfer_log.size() - bx);
    else n_pass++;
    if (ok && xfer_log.size() - bx == 4) begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (done_log[bd + i].who !== 1 || done_log[bd + i].rdata !== expq1[e1])
          $display("FAIL b2b_rdata%0d: got r%0d %h expected r1 %h", i, done_log[bd + i].who, done_log[bd + i].rdata, expq1[e1]);
        else n_pass++;
        e1++;
        if (i > 0) begin
          n_checks++;
          if (xfer_log[bx + i].cyc !== done_log[bd + i - 1].cyc + 2)
            $display("FAIL b2b_gap%0d: got transfer cycle %0d expected %0d", i, xfer_log[bx + i].cyc, done_log[bd + i - 1].cyc + 2);
          else n_pass++;
        end
      end
    end
    e0 = expq0.size(); e1 = expq1.size();
  endtask

  task automatic test_fairness();
    int bd; bit ok;
    logic [31:0] ex;
    bd = done_log.size();
    @(negedge PCLK);
    for (int i = 0; i < 3; i++) begin
      push_txn(0, 32'h1000_5000 + 32'(4 * i), 32'd0, 1'b0);
      push_txn(1, 32'h1000_6000 + 32'(4 * i), 32'd0, 1'b0);
    end
    wait_done(bd + 6, 200, ok);
    n_checks++;
    if (!ok) $display("FAIL fair_done: got %0d completions expected 6", done_log.size() - bd); else n_pass++;
    if (ok) begin
      for (int i = 0; i < 6; i++) begin
        n_checks++;
        if (done_log[bd + i].who !== i % 2)
          $display("FAIL fair_grant%0d: got r%0d expected r%0d", i, done_log[bd + i].who, i % 2);
        else n_pass++;
        if (done_log[bd + i].who == 0) begin ex = expq0[e0]; e0++; end
        else begin ex = expq1[e1]; e1++; end
        n_checks++;
        if (done_log[bd + i].rdata !== ex)
          $display("FAIL fair_rdata%0d: got %h expected %h", i, done_log[bd + i].rdata, ex);
        else n_pass++;
      end
    end
    repeat (3) @(posedge PCLK);
    e0 = expq0.size(); e1 = expq1.size();
  endtask

  task automatic test_reset_mid_wait();
    int bd, bx; bit ok, seen;
    logic [67:0] v;
    bd = done_log.size();
    @(negedge PCLK); push_txn(0, 32'h1000_7000, 32'd0, 1'b0);
    wait_done(bd + 1, 40, ok);
    n_checks++;
    if (!ok || done_log[bd].who !== 0) $display("FAIL rstw_pre: got no r0 completion expected one"); else n_pass++;
    repeat (2) @(posedge PCLK);
    bx = xfer_log.size(); bd = done_log.size(); seen = 0;
    @(negedge PCLK); push_txn(0, 32'h1000_7004, 32'd0, 1'b0);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge PCLK);
      if (xfer_log.size() > bx) seen = 1;
    end
    n_checks++;
    if (!seen) $display("FAIL rstw_xfer: got no transfer expected one"); else n_pass++;
    #2 PRESET = 1'b1;
    #1;
    v = {bus.transfer, bus.r0_ready, bus.r1_ready, bus.err, bus.addr, bus.wdata};
    n_checks++;
    if (v !== '0) $display("FAIL rstw_async: got %h expected 0", v); else n_pass++;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK); PRESET = 1'b0;
    e0 = expq0.size(); e1 = expq1.size();
    repeat (8) @(posedge PCLK);
    n_checks++;
    if (done_log.size() !== bd) $display("FAIL rstw_abort: got %0d completions expected 0", done_log.size() - bd);
    else n_pass++;
    @(negedge PCLK);
    push_txn(0, 32'h1000_7100, 32'd0, 1'b0);
    push_txn(1, 32'h1000_7200, 32'd0, 1'b0);
    wait_done(bd + 2, 60, ok);
    n_checks++;
    if (!ok || done_log[bd].who !== 0 || done_log[bd].rdata !== expq0[e0])
      $display("FAIL rstw_tie: got r%0d %h expected r0 %h", ok ? done_log[bd].who : -1, ok ? done_log[bd].rdata : 32'd0, expq0[e0]);
    else n_pass++;
    repeat (3) @(posedge PCLK);
    e0 = expq0.size(); e1 = expq1.size();
  endtask

`ifdef APB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int bd, bx; bit ok;
    bd = done_log.size(); bx = xfer_log.size();
    @(negedge PCLK); slave_hang = 1'b1; push_txn(1, 32'h1000_8000, 32'd0, 1'b0);
    wait_done(bd + 1, 60, ok);
    n_checks++;
    if (!ok || done_log[bd].err !== 1'b1 || done_log[bd].rdata !== 32'hDEAD_BEEF)
      $display("FAIL tmo_err: got err %b rdata %h expected 1 deadbeef", ok ? done_log[bd].err : 1'b0, ok ? done_log[bd].rdata : 32'd0);
    else n_pass++;
    n_checks++;
    if (!ok || done_log[bd].cyc - xfer_log[bx].cyc !== 17)
      $display("FAIL tmo_latency: got %0d expected 17", ok ? done_log[bd].cyc - xfer_log[bx].cyc : -1);
    else n_pass++;
    repeat (3) @(posedge PCLK);
    bd = done_log.size(); e1 = expq1.size();
    @(negedge PCLK); slave_hang = 1'b0; push_txn(1, 32'h1000_8004, 32'd0, 1'b0);
    wait_done(bd + 1, 40, ok);
    n_checks++;
    if (!ok || done_log[bd].err !== 1'b0 || done_log[bd].rdata !== expq1[e1])
      $display("FAIL tmo_next: got err %b rdata %h expected 0 %h", ok ? done_log[bd].err : 1'b1, ok ? done_log[bd].rdata : 32'd0, expq1[e1]);
    else n_pass++;
  endtask
`endif

  initial begin
    PRESET = 1'b1; slave_hang = 1'b0; inject_ready = 1'b0; e0 = 0; e1 = 0;
    test_reset();
    test_single_read();
    test_simultaneous();
    test_back_to_back();
    test_fairness();
    test_reset_mid_wait();
`ifdef APB_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
- Shares the single internal CPU-side trigger interface of the APB master (transfer/ready/addr/wdata/write/rdata) between two requesters.
- Requester 0 is the RV32I core data port; requester 1 is a secondary bus master, e.g. a UART-to-RAM/peripheral copy engine.
- Round-robin arbitration; exactly one bus transaction is outstanding at a time.
- Sits between the requesters and the APB master inside the MCU top.

Parameters:
- TIMEOUT_CYCLES, 1024: downstream ready watchdog limit, used only with the optional feature.
- ERR_DATA, 32'hDEAD_BEEF: read data returned on a timed-out transaction.

Ports:
- PCLK  input  1  system clock
- PRESET  input  1  asynchronous active-high reset
- r0_req  input  1  requester 0 transaction request (level)
- r0_addr  input  32  requester 0 address
- r0_wdata  input  32  requester 0 write data
- r0_write  input  1  requester 0 direction: 1 write, 0 read
- r0_ready  output  1  requester 0 completion pulse
- r0_rdata  output  32  requester 0 read data, valid while r0_ready=1
- r1_req, r1_addr, r1_wdata, r1_write, r1_ready, r1_rdata: same as requester 0, for requester 1
- transfer  output  1  one-cycle trigger to the APB master
- addr  output  32  latched address to the APB master
- wdata  output  32  latched write data to the APB master
- write  output  1  latched direction to the APB master
- ready  input  1  APB master completion
- rdata  input  32  APB master read data, valid with ready
- err  output  1  timeout flag, pulses with rN_ready (optional feature only; tied 0 otherwise)

Behaviour:
- Clock and reset: single clock PCLK; reset PRESET is asynchronous and active-high.
- Reset values:
  - state=IDLE, last_grant=1 (so requester 0 wins the first tie).
  - transfer=0, r0_ready=r1_ready=0, err=0.
  - addr/wdata/write/r0_rdata/r1_rdata all 0.
- Requester contract: rN_req, addr, wdata and write are held stable from assertion until the rN_ready cycle. The requester drops rN_req on the edge after rN_ready unless it issues a new request.
- FSM IDLE:
  - If exactly one request is high, grant it.
  - If both are high, grant the requester not equal to last_grant.
  - Latch that requester's addr/wdata/write into the addr/wdata/write registers, record gnt, go to ISSUE.
  - If no request is high, stay in IDLE.
- FSM ISSUE: transfer=1 for exactly this cycle; go to WAIT.
- FSM WAIT:
  - transfer=0; addr/wdata/write stay constant.
  - On ready=1: capture rdata into r{gnt}_rdata (on writes too; the value is don't-care), set last_grant=gnt, go to DONE.
- FSM DONE:
  - r{gnt}_ready=1 for one cycle; r{gnt}_rdata is valid.
  - Go to IDLE.
- Latency: request sampled in IDLE at cycle t; transfer at t+1; earliest rN_ready at (cycle ready is seen)+1.
- The loser's request stays pending; it is never dropped or reordered.
- rN_rdata holds its value until the next completion for that same requester.
- ready seen outside WAIT is ignored.
- A request that deasserts before it is granted is simply not served. Deasserting after grant is a protocol violation; the transaction still completes.
- Reset mid-transaction: everything returns to reset values immediately; no rN_ready is generated for the aborted access.
- No combinational path from rN_req to transfer.

Optional Feature:
- Macro: APB_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES with ready still low, go to DONE with r{gnt}_rdata=ERR_DATA and err=1 during the DONE cycle.
  - last_grant updates as on a normal completion.
  - A late ready after a timeout is ignored.
- Undefined: no counter; WAIT waits for ready indefinitely; err is constant 0.

Test Plan:
- Single read: r0_req with addr 0x1000_0000 and a model returning rdata 0x0000_00A5 three cycles after transfer -> one transfer pulse, addr=0x1000_0000, write=0; r0_ready one cycle with r0_rdata=0x0000_00A5; r1_ready never asserts.
- Simultaneous requests right after reset: r0 write 0x55 to 0x1000_2000, r1 read of 0x1000_3000 -> r0 is served first; r1's transfer starts only after r0_ready; the transfer sequence is [0x1000_2000 W, 0x1000_3000 R].
- Fairness: both requesters hold req continuously for 6 transactions -> grants strictly alternate 0,1,0,1,0,1; each requester gets 3 rN_ready pulses.
- Back-to-back single requester: r1 reissues immediately after each r1_ready for 4 reads, r0 idle -> 4 transfers, each preceded by one IDLE cycle; all r1_rdata values match the model.
- Reset mid-WAIT: assert PRESET while in WAIT -> transfer, r0_ready and r1_ready go 0 asynchronously; after release, the first tie is granted to r0 again.
- With APB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: ready never returns -> rN_ready and err pulse at WAIT cycle 16 with rN_rdata=0xDEAD_BEEF; the next request is served normally.
